// File: rtl/clk_divider_bank.sv
// ---------------------------------------------------------------------------
// clk_divider_bank
// Purpose:
//   A bank of N_CH independent integer clock dividers running from one source
//   clock. Each channel divides by any integer D with 50% duty cycle. For odd D,
//   the half-cycle extension comes from a negedge-retimed copy of the posedge
//   phase. Ratios are written through a valid/ready port into a per-channel
//   shadow register. The shadow is promoted only at a period boundary, so a
//   ratio change never produces a runt pulse.
// Ports:
//   clk_in        source clock (both edges are used)
//   rst_n         asynchronous active-low reset
//   cfg_valid     ratio write request
//   cfg_ready     write can be accepted (target channel has no pending ratio)
//   cfg_ch        target channel of the write
//   cfg_div       new ratio D (0 or 1 selects bypass: clk_out follows clk_in)
//   sync_restart  one-cycle pulse that restarts every channel in phase
//   clk_out       divided clocks, one per channel
//   tick          one-cycle enable, high in the first cycle of each period
//   pending       a shadow ratio is waiting for its period boundary
// ---------------------------------------------------------------------------
module clk_divider_bank #(
    parameter int N_CH        = 4,
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 2,
    localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CW-1:0]   cfg_ch,
    input  logic [W-1:0]    cfg_div,
    input  logic            sync_restart,
    output logic [N_CH-1:0] clk_out,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] pending
);

    // Ready reflects the addressed channel only. A channel index beyond the
    // bank matches nothing, so the write is accepted and silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CW'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [W-1:0] cnt;
        logic [W-1:0] act_div;
        logic [W-1:0] shd_div;
        logic [W-1:0] d_last;
        logic [W-1:0] cnt_next;
        logic [W-1:0] div_next;
        logic         pend_r;
        logic         tick_r;
        logic         p;
        logic         n;
        logic         bypass;
        logic         wrap;
        logic         wr_en;

        // In bypass every posedge counts as a period boundary, which lets a
        // pending ratio take over on the very next edge.
        assign bypass   = (act_div <= W'(1));
        assign d_last   = act_div - W'(1);
        assign wrap     = bypass || (cnt == d_last) || sync_restart;
        assign cnt_next = wrap ? '0 : cnt + W'(1);
        assign wr_en    = cfg_valid && cfg_ready && (cfg_ch == CW'(g));
        // Ratio governing the period that cnt_next belongs to.
        assign div_next = (wrap && pend_r) ? shd_div : act_div;

        // Posedge state. A write can only land while nothing is pending, so it
        // never competes with promotion; a write coinciding with a wrap stays
        // in the shadow until the following wrap.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt     <= '0;
                act_div <= W'(DEFAULT_DIV);
                shd_div <= W'(DEFAULT_DIV);
                pend_r  <= 1'b0;
                p       <= 1'b0;
                tick_r  <= 1'b0;
            end else begin
                cnt    <= cnt_next;
                p      <= (cnt_next < (div_next >> 1));
                tick_r <= (cnt_next == '0);
                if (wr_en) begin
                    shd_div <= cfg_div;
                    pend_r  <= 1'b1;
                end else if (wrap && pend_r) begin
                    act_div <= shd_div;
                    pend_r  <= 1'b0;
                end
            end
        end

        // Half-cycle delayed copy of p; OR-ing it in stretches the high phase
        // by half a clk_in period for odd ratios.
        always_ff @(negedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                n <= 1'b0;
            end else begin
                n <= p;
            end
        end

        // Entering or leaving bypass happens at a posedge, where clk_in is
        // rising and p has just been loaded for the new period, so the mux
        // switches between agreeing levels.
        assign clk_out[g] = bypass ? clk_in : (act_div[0] ? (p | n) : p);
        assign tick[g]    = tick_r;
        assign pending[g] = pend_r;
    end

endmodule

// File: tb/tb_clk_divider_bank.sv
// ---------------------------------------------------------------------------
// tb_clk_divider_bank
// Purpose:
//   Self-checking bench for clk_divider_bank (3 channels, 8-bit ratios).
//   Stimulus pushes the expected period shape into per-channel queues. Each
//   entry holds the total half-cycles and high half-cycles of one period.
//   A monitor measures every period, delimited by tick, and pops and compares
//   one queue entry each time a period completes.
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_clk_divider_bank;
    localparam int N_CH = 3;
    localparam int W    = 8;

    logic            clk_in       = 1'b0;
    logic            rst_n        = 1'b1;
    logic            cfg_valid    = 1'b0;
    logic            sync_restart = 1'b0;
    logic [1:0]      cfg_ch       = 2'd0;
    logic [W-1:0]    cfg_div      = '0;
    logic            cfg_ready;
    logic [N_CH-1:0] clk_out;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] pending;

    int checks = 0;
    int errors = 0;

    // Each entry is period_halves*256 + high_halves.
    int unsigned exp_q [N_CH][$];

    clk_divider_bank #(
        .N_CH(N_CH),
        .W(W),
        .DEFAULT_DIV(2)
    ) dut (
        .clk_in(clk_in),
        .rst_n(rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .sync_restart(sync_restart),
        .clk_out(clk_out),
        .tick(tick),
        .pending(pending)
    );

    // Source clock with a period of 10 time units.
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int c, input int count, input int halves, input int high);
        for (int i = 0; i < count; i++) begin
            exp_q[c].push_back(int'(halves * 256 + high));
        end
    endtask

    // Called from negedge context. Waits for ready, holds valid for one
    // posedge, then checks that the pending flag and cfg_ready reflect the write.
    task automatic applyStimulus(input int c, input int d);
        int k;
        k = 0;
        cfg_ch  = 2'(c);
        cfg_div = W'(d);
        while (!cfg_ready && k < 300) begin
            @(negedge clk_in);
            k++;
        end
        checkOutput($sformatf("ch%0d ready before write", c), 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        if (c < N_CH) begin
            checkOutput($sformatf("ch%0d pending after write", c), 32'(pending[c]), 32'd1);
            checkOutput($sformatf("ch%0d ready after write", c), 32'(cfg_ready), 32'd0);
        end else begin
            checkOutput("dropped write pending", 32'(pending), 32'd0);
            checkOutput("dropped write ready", 32'(cfg_ready), 32'd1);
        end
    endtask

    task automatic waitPendingClear(input int c);
        int k;
        k = 0;
        while (pending[c] && k < 300) begin
            @(negedge clk_in);
            k++;
        end
        checkOutput($sformatf("ch%0d pending clears", c), 32'(pending[c]), 32'd0);
    endtask

    task automatic waitDrain();
        int total;
        for (int k = 0; k < 400; k++) begin
            total = 0;
            for (int c = 0; c < N_CH; c++) total += exp_q[c].size();
            if (total == 0) break;
            @(negedge clk_in);
        end
        total = 0;
        for (int c = 0; c < N_CH; c++) total += exp_q[c].size();
        checkOutput("expected queue drained", 32'(total), 32'd0);
        for (int c = 0; c < N_CH; c++) exp_q[c].delete();
    endtask

    // Monitor: samples clk_out just after each clk_in edge to count high
    // half-cycles. A tick marks the first cycle of a new period and closes
    // the previous measurement.
    initial begin
        int          half_total [N_CH];
        int          half_high  [N_CH];
        bit          started    [N_CH];
        int unsigned e;
        for (int c = 0; c < N_CH; c++) begin
            started[c]    = 1'b0;
            half_total[c] = 0;
            half_high[c]  = 0;
        end
        forever begin
            @(posedge clk_in);
            #1;
            for (int c = 0; c < N_CH; c++) begin
                if (!rst_n) begin
                    started[c] = 1'b0;
                end else if (tick[c]) begin
                    if (started[c] && exp_q[c].size() > 0) begin
                        e = exp_q[c].pop_front();
                        checkOutput($sformatf("ch%0d period halves", c), 32'(half_total[c]), 32'(e >> 8));
                        checkOutput($sformatf("ch%0d high halves", c), 32'(half_high[c]), 32'(e & 32'd255));
                    end
                    started[c]    = 1'b1;
                    half_total[c] = 1;
                    half_high[c]  = int'(clk_out[c]);
                end else if (started[c]) begin
                    half_total[c]++;
                    half_high[c] += int'(clk_out[c]);
                end
            end
            @(negedge clk_in);
            #1;
            for (int c = 0; c < N_CH; c++) begin
                if (!rst_n) begin
                    started[c] = 1'b0;
                end else if (started[c]) begin
                    half_total[c]++;
                    half_high[c] += int'(clk_out[c]);
                end
            end
        end
    end

    // Watchdog so that the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int found;

        // Reset state.
        #1;
        rst_n = 1'b0;
        #2;
        checkOutput("reset clk_out", 32'(clk_out), 32'd0);
        checkOutput("reset tick", 32'(tick), 32'd0);
        checkOutput("reset pending", 32'(pending), 32'd0);
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd1);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;

        // Default ratio 2 on every channel.
        for (int c = 0; c < N_CH; c++) pushExp(c, 3, 4, 2);
        waitDrain();

        // ch0 -> D=4; the other channels keep running at D=2.
        applyStimulus(0, 4);
        waitPendingClear(0);
        pushExp(0, 3, 8, 4);
        pushExp(1, 2, 4, 2);
        pushExp(2, 2, 4, 2);
        waitDrain();

        // A write to a channel outside the bank is accepted and dropped.
        applyStimulus(3, 9);
        pushExp(0, 2, 8, 4);
        pushExp(1, 2, 4, 2);
        pushExp(2, 2, 4, 2);
        waitDrain();

        // ch1 -> D=5: 2.5 cycles high, 2.5 cycles low.
        applyStimulus(1, 5);
        waitPendingClear(1);
        pushExp(1, 3, 10, 5);
        waitDrain();

        // ch2 -> bypass, then -> D=3.
        applyStimulus(2, 1);
        waitPendingClear(2);
        pushExp(2, 4, 2, 1);
        waitDrain();
        applyStimulus(2, 3);
        waitPendingClear(2);
        pushExp(2, 3, 6, 3);
        waitDrain();

        // ch1 -> D=6, then restart all channels in phase.
        applyStimulus(1, 6);
        waitPendingClear(1);
        waitDrain();
        sync_restart = 1'b1;
        @(posedge clk_in);
        #1;
        checkOutput("restart tick ch0", 32'(tick[0]), 32'd1);
        checkOutput("restart tick ch1", 32'(tick[1]), 32'd1);
        @(negedge clk_in);
        sync_restart = 1'b0;
        pushExp(0, 3, 8, 4);
        pushExp(1, 2, 12, 6);
        pushExp(2, 3, 6, 3);
        found = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk_in);
            #1;
            if (tick[0] && tick[1]) begin
                found = k;
                break;
            end
        end
        checkOutput("ch0/ch1 tick coincidence cycles", 32'(found), 32'd12);
        @(negedge clk_in);
        waitDrain();

        // Reset mid-period with a write pending.
        applyStimulus(0, 7);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset clk_out", 32'(clk_out), 32'd0);
        checkOutput("mid reset tick", 32'(tick), 32'd0);
        checkOutput("mid reset pending", 32'(pending), 32'd0);
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        for (int c = 0; c < N_CH; c++) pushExp(c, 2, 4, 2);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
